binary_frame_scanner: RTL and testbench



---
 rtl/binary_frame_scanner.sv | 150 +++++++++++++++
 tb/tb_binary_frame_scanner.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_frame_scanner.sv
// Raster-scans the 1-bit frame BRAM and feeds the 3-line binary line buffer, flush lines included.
// Outputs trail the BRAM read by READ_LATENCY cycles; hold_in stalls only between lines, ACTIVE never stalls.
module binary_frame_scanner #(
    parameter int H_ACTIVE     = 320,
    parameter int V_ACTIVE     = 240,
    parameter int FLUSH_LINES  = 2,
    parameter int H_GAP        = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        hold_in,
    output logic [16:0] addr_out,
    output logic        rd_en_out,
    input  logic        pixel_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        pixel_out,
    output logic        data_valid_out,
    output logic        busy_out,
    output logic        done_out
);

    localparam int LINES     = V_ACTIVE + FLUSH_LINES;
    localparam int ADDR_LAST = H_ACTIVE * V_ACTIVE - 1;
    localparam int TAIL      = READ_LATENCY - 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]  state;
    logic [10:0] h;
    logic [9:0]  v;
    logic [16:0] addr;
    logic [15:0] gap_cnt;
    logic [7:0]  drain_cnt;

    logic issue;
    logic real_line;
    logic rd;

    assign issue     = (state == S_ACTIVE);
    assign real_line = (v < 10'(V_ACTIVE));
    assign rd        = issue && real_line;

    assign rd_en_out = rd;
    assign addr_out  = addr;
    assign busy_out  = (state != S_IDLE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= S_IDLE;
            h         <= '0;
            v         <= '0;
            addr      <= '0;
            gap_cnt   <= '0;
            drain_cnt <= '0;
            done_out  <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A start landing on the done pulse belongs to the frame just finished.
                    if (start_in && !done_out) begin
                        h     <= '0;
                        v     <= '0;
                        addr  <= '0;
                        state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (rd && (addr != 17'(ADDR_LAST))) begin
                        addr <= addr + 17'd1;
                    end
                    if (h == 11'(H_ACTIVE - 1)) begin
                        h         <= '0;
                        gap_cnt   <= '0;
                        drain_cnt <= '0;
                        if (v == 10'(LINES - 1)) begin
                            state <= S_DRAIN;
                        end else begin
                            v     <= v + 10'd1;
                            state <= S_GAP;
                        end
                    end else begin
                        h <= h + 11'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 16'(H_GAP - 1)) begin
                        if (!hold_in) begin
                            state <= S_ACTIVE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: begin
                    if (drain_cnt == 8'(READ_LATENCY - 1)) begin
                        state    <= S_IDLE;
                        done_out <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    // Side-band pipeline; h/v only advance behind a valid beat so the tail holds the last coordinates.
    logic [10:0] sb_h     [READ_LATENCY];
    logic [9:0]  sb_v     [READ_LATENCY];
    logic        sb_vld   [READ_LATENCY];
    logic        sb_flush [READ_LATENCY];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                sb_h[i]     <= '0;
                sb_v[i]     <= '0;
                sb_vld[i]   <= 1'b0;
                sb_flush[i] <= 1'b0;
            end
        end else begin
            sb_vld[0]   <= issue;
            sb_flush[0] <= issue && !real_line;
            if (issue) begin
                sb_h[0] <= h;
                sb_v[0] <= v;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                sb_vld[i]   <= sb_vld[i-1];
                sb_flush[i] <= sb_flush[i-1];
                if (sb_vld[i-1]) begin
                    sb_h[i] <= sb_h[i-1];
                    sb_v[i] <= sb_v[i-1];
                end
            end
        end
    end

    assign hcount_out     = sb_h[TAIL];
    assign vcount_out     = sb_v[TAIL];
    assign data_valid_out = sb_vld[TAIL];
    assign pixel_out      = sb_vld[TAIL] && !sb_flush[TAIL] && pixel_in;

endmodule

// File: tb/tb_binary_frame_scanner.sv
// Bench for binary_frame_scanner: two reduced-size builds, BRAM models and a beat-order reference model.
`timescale 1ns/1ps
module tb_binary_frame_scanner;

    localparam int AH = 32, AV = 6, AF = 2, AG = 4, AR = 2, AL = AV + AF;
    localparam int BH = 16, BV = 3, BF = 2, BG = 1, BR = 1, BL = BV + BF;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame contents: mode 0 = address LSB, mode 1 = checkerboard.
    function automatic int mem_bit(input int mode, input int h_act, input int a);
        if (mode == 0) return a % 2;
        return ((a % h_act) + (a / h_act)) % 2;
    endfunction

    // ---------------- DUT A ----------------
    logic        a_rst = 1'b1, a_start = 1'b0, a_hold = 1'b0;
    logic [16:0] a_addr;
    logic        a_rd_en, a_pix_in, a_pix, a_dv, a_busy, a_done;
    logic [10:0] a_hc;
    logic [9:0]  a_vc;
    int          a_mode = 1;

    binary_frame_scanner #(.H_ACTIVE(AH), .V_ACTIVE(AV), .FLUSH_LINES(AF), .H_GAP(AG), .READ_LATENCY(AR)) dut_a (
        .clk_in(clk_in), .rst_in(a_rst), .start_in(a_start), .hold_in(a_hold),
        .addr_out(a_addr), .rd_en_out(a_rd_en), .pixel_in(a_pix_in),
        .hcount_out(a_hc), .vcount_out(a_vc), .pixel_out(a_pix), .data_valid_out(a_dv),
        .busy_out(a_busy), .done_out(a_done));

    // BRAM returns 1 on unread cycles so flush-line forcing is visible.
    logic a_rp [AR];
    always @(posedge clk_in) begin
        a_rp[0] <= a_rd_en ? mem_bit(a_mode, AH, int'(a_addr)) != 0 : 1'b1;
        for (int i = 1; i < AR; i++) a_rp[i] <= a_rp[i-1];
    end
    assign a_pix_in = a_rp[AR-1];

    int a_seq = 0, a_seen_seq = 0, a_t0 = 0, a_beats = 0, a_rdc = 0, a_ndone = 0;
    int a_last_rel = -1, a_eh, a_ev, a_lh = 0, a_lv = 0;
    bit a_mon = 0, a_timing = 0, a_any = 0, a_fin = 0;

    always @(negedge clk_in) begin
        if (a_done) a_ndone++;
        if (!a_mon) begin
            a_any = 0;
        end else begin
            if (a_seq != a_seen_seq) begin
                a_seen_seq = a_seq;
                a_beats    = 0;
                a_rdc      = 0;
            end
            chk("a_addr_bound", longint'(a_addr > 17'(AH*AV-1)), 0);
            if (a_rd_en) begin
                chk("a_rd_addr", longint'(a_addr), a_rdc);
                a_rdc++;
            end
            if (a_dv) begin
                a_eh = a_beats % AH;
                a_ev = a_beats / AH;
                chk("a_hcount", longint'(a_hc), a_eh);
                chk("a_vcount", longint'(a_vc), a_ev);
                chk("a_pixel", longint'(a_pix), (a_ev < AV) ? mem_bit(a_mode, AH, a_ev*AH + a_eh) : 0);
                if (a_timing) chk("a_beat_time", cyc - a_t0, 1 + AR + a_ev*(AH+AG) + a_eh);
                a_lh = a_eh;
                a_lv = a_ev;
                a_any = 1;
                a_beats++;
                a_last_rel = cyc - a_t0;
            end else if (a_any) begin
                chk("a_hcount_hold", longint'(a_hc), a_lh);
                chk("a_vcount_hold", longint'(a_vc), a_lv);
            end
        end
    end

    task automatic a_at(input int k);
        do @(negedge clk_in); while (cyc - a_t0 < k);
    endtask

    task automatic a_begin(input int mode, input bit timing);
        a_mode   = mode;
        a_timing = timing;
        a_t0     = cyc;
        a_seq++;
        a_mon    = 1;
        a_start  = 1'b1;
        a_at(1);
        a_start  = 1'b0;
    endtask

    task automatic a_wait_done(input int limit);
        int n = 0;
        while (!a_done && n < limit) begin
            @(negedge clk_in);
            n++;
        end
        chk("a_done_seen", longint'(a_done), 1);
    endtask

    task automatic a_chk_zero(input string tag);
        chk({tag, "_addr"}, longint'(a_addr), 0);
        chk({tag, "_rd_en"}, longint'(a_rd_en), 0);
        chk({tag, "_hcount"}, longint'(a_hc), 0);
        chk({tag, "_vcount"}, longint'(a_vc), 0);
        chk({tag, "_pixel"}, longint'(a_pix), 0);
        chk({tag, "_valid"}, longint'(a_dv), 0);
        chk({tag, "_busy"}, longint'(a_busy), 0);
        chk({tag, "_done"}, longint'(a_done), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        a_chk_zero("a_reset");
        a_rst = 1'b0;
        repeat (2) @(negedge clk_in);

        // Frame 1: checkerboard, exact timing.
        a_begin(1, 1);
        chk("a_c1_rd_en", longint'(a_rd_en), 1);
        chk("a_c1_addr", longint'(a_addr), 0);
        chk("a_c1_busy", longint'(a_busy), 1);
        chk("a_c1_valid", longint'(a_dv), 0);
        a_at(1 + AR);
        chk("a_first_valid", longint'(a_dv), 1);
        chk("a_first_h", longint'(a_hc), 0);
        chk("a_first_v", longint'(a_vc), 0);
        a_at(1 + AR + AH);
        chk("a_gap_valid", longint'(a_dv), 0);
        a_at(37);
        chk("a_line1_rd_en", longint'(a_rd_en), 1);
        chk("a_line1_addr", longint'(a_addr), 32);
        a_wait_done(400);
        chk("a_done_cycle", cyc - a_t0, 287);
        chk("a_last_valid_cycle", a_last_rel, 286);
        chk("a_busy_at_done", longint'(a_busy), 0);
        chk("a_beat_total", a_beats, AL*AH);
        a_start = 1'b1;
        @(negedge clk_in);
        a_start = 1'b0;
        chk("a_start_on_done_busy", longint'(a_busy), 0);
        chk("a_start_on_done_rd_en", longint'(a_rd_en), 0);
        @(negedge clk_in);
        chk("a_start_on_done_busy2", longint'(a_busy), 0);

        // Frame 2: LSB data, mid-frame start, hold between lines 2 and 3.
        a_begin(0, 0);
        a_at(1 + AR + 5);
        chk("a_align_valid", longint'(a_dv), 1);
        chk("a_align_h", longint'(a_hc), 5);
        chk("a_align_v", longint'(a_vc), 0);
        chk("a_align_pixel", longint'(a_pix), 1);
        a_at(50);
        a_start = 1'b1;
        a_at(51);
        a_start = 1'b0;
        a_at(80);
        a_hold = 1'b1;
        a_at(100);
        chk("a_hold_in_active_valid", longint'(a_dv), 1);
        chk("a_hold_in_active_h", longint'(a_hc), 25);
        for (int k = 106; k < 140; k++) begin
            a_at(k);
            chk("a_stall_rd_en", longint'(a_rd_en), 0);
            if (k >= 107) chk("a_stall_valid", longint'(a_dv), 0);
        end
        a_at(140);
        a_hold = 1'b0;
        chk("a_release_rd_en", longint'(a_rd_en), 0);
        a_at(141);
        chk("a_resume_rd_en", longint'(a_rd_en), 1);
        chk("a_resume_addr", longint'(a_addr), 96);
        a_at(143);
        chk("a_resume_valid", longint'(a_dv), 1);
        chk("a_resume_v", longint'(a_vc), 3);
        a_wait_done(600);
        chk("a_done_cycle_hold", cyc - a_t0, 319);
        chk("a_beat_total_hold", a_beats, AL*AH);
        @(negedge clk_in);

        // Frame 3: restart the cycle after done, then reset mid-line.
        a_begin(1, 1);
        chk("a_restart_busy", longint'(a_busy), 1);
        chk("a_restart_rd_en", longint'(a_rd_en), 1);
        chk("a_restart_addr", longint'(a_addr), 0);
        a_at(1 + 4*(AH+AG) + 7);
        a_rst = 1'b1;
        a_mon = 0;
        @(negedge clk_in);
        a_chk_zero("a_midrst");
        a_start = 1'b1;
        @(negedge clk_in);
        a_start = 1'b0;
        a_rst   = 1'b0;
        @(negedge clk_in);
        chk("a_start_during_rst", longint'(a_busy), 0);
        for (int k = 0; k < 350; k++) begin
            @(negedge clk_in);
            chk("a_no_done_after_rst", longint'(a_done), 0);
        end

        // Frame 4: full frame after the abort.
        a_begin(1, 1);
        a_wait_done(400);
        chk("a_done_cycle_after_rst", cyc - a_t0, 287);
        chk("a_beat_total_after_rst", a_beats, AL*AH);
        chk("a_busy_after_rst_frame", longint'(a_busy), 0);
        @(negedge clk_in);
        chk("a_done_count", a_ndone, 3);
        a_fin = 1;
    end

    // ---------------- DUT B: single-cycle gap, latency 1 ----------------
    logic        b_rst = 1'b1, b_start = 1'b0, b_hold = 1'b0;
    logic [16:0] b_addr;
    logic        b_rd_en, b_pix_in, b_pix, b_dv, b_busy, b_done;
    logic [10:0] b_hc;
    logic [9:0]  b_vc;

    binary_frame_scanner #(.H_ACTIVE(BH), .V_ACTIVE(BV), .FLUSH_LINES(BF), .H_GAP(BG), .READ_LATENCY(BR)) dut_b (
        .clk_in(clk_in), .rst_in(b_rst), .start_in(b_start), .hold_in(b_hold),
        .addr_out(b_addr), .rd_en_out(b_rd_en), .pixel_in(b_pix_in),
        .hcount_out(b_hc), .vcount_out(b_vc), .pixel_out(b_pix), .data_valid_out(b_dv),
        .busy_out(b_busy), .done_out(b_done));

    logic b_rp;
    always @(posedge clk_in) b_rp <= b_rd_en ? mem_bit(1, BH, int'(b_addr)) != 0 : 1'b1;
    assign b_pix_in = b_rp;

    int b_t0 = 0, b_beats = 0, b_rdc = 0, b_eh, b_ev, b_lh = 0, b_lv = 0;
    bit b_mon = 0, b_any = 0, b_fin = 0;

    always @(negedge clk_in) begin
        if (b_mon) begin
            if (b_rd_en) begin
                chk("b_rd_addr", longint'(b_addr), b_rdc);
                b_rdc++;
            end
            if (b_dv) begin
                b_eh = b_beats % BH;
                b_ev = b_beats / BH;
                chk("b_hcount", longint'(b_hc), b_eh);
                chk("b_vcount", longint'(b_vc), b_ev);
                chk("b_pixel", longint'(b_pix), (b_ev < BV) ? mem_bit(1, BH, b_ev*BH + b_eh) : 0);
                chk("b_beat_time", cyc - b_t0, 1 + BR + b_ev*(BH+BG) + b_eh);
                b_lh = b_eh;
                b_lv = b_ev;
                b_any = 1;
                b_beats++;
            end else if (b_any) begin
                chk("b_hcount_hold", longint'(b_hc), b_lh);
                chk("b_vcount_hold", longint'(b_vc), b_lv);
            end
        end
    end

    task automatic b_at(input int k);
        do @(negedge clk_in); while (cyc - b_t0 < k);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk_in);
        chk("b_reset_valid", longint'(b_dv), 0);
        chk("b_reset_busy", longint'(b_busy), 0);
        b_rst = 1'b0;
        @(negedge clk_in);
        b_t0    = cyc;
        b_mon   = 1;
        b_start = 1'b1;
        b_at(1);
        b_start = 1'b0;
        chk("b_c1_valid", longint'(b_dv), 0);
        chk("b_c1_rd_en", longint'(b_rd_en), 1);
        b_at(2);
        chk("b_first_valid", longint'(b_dv), 1);
        chk("b_first_h", longint'(b_hc), 0);
        b_at(18);
        chk("b_line1_rd_en", longint'(b_rd_en), 1);
        chk("b_line1_addr", longint'(b_addr), 16);
        b_at(19);
        chk("b_line1_valid", longint'(b_dv), 1);
        chk("b_line1_v", longint'(b_vc), 1);
        n = 0;
        while (!b_done && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        chk("b_done_seen", longint'(b_done), 1);
        chk("b_done_cycle", cyc - b_t0, 86);
        chk("b_busy_at_done", longint'(b_busy), 0);
        chk("b_beat_total", b_beats, BL*BH);
        b_fin = 1;
    end

    initial begin
        int n = 0;
        while (!(a_fin && b_fin) && n < 5000) begin
            @(negedge clk_in);
            n++;
        end
        if (!(a_fin && b_fin)) chk("tb_timeout", 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
